uart_tx_ctrl: RTL and testbench

UART transmit sequencer. Accepts parallel words over a valid/ready handshake and serialises them LSB-first on a single line as start bit, data bits, optional parity bit and 1 or 2 stop bits. It owns two counters: a baud-period counter that sets bit timing and a bit-index counter that steps through the frame. It sits between the UART host-side register interface and the tx pin.

---
 rtl/uart_tx_ctrl_if.sv | 12 +
 rtl/uart_tx_ctrl.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Host-side word handshake into the UART transmit sequencer.
// The host drives data/valid; the sequencer answers with ready.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Frame settings are captured at accept so host-side changes never disturb a frame on the wire.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_ctrl_if.slave        host,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 two_stop_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  parity_q, parity_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wrap;

  assign wrap          = (baud_q == div_q);
  assign host.tx_ready = ready_q;
  assign tx_o          = tx_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = done_q;

  // tx_d is the line level for the cycle after this edge, so the shifter
  // pops the next data bit at the wrap that ends the previous bit.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    parity_d   = parity_q;
    two_stop_d = two_stop_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (host.tx_valid && ready_q) begin
          shift_d    = host.tx_data;
          div_d      = baud_div_i;
          par_en_d   = parity_en_i;
          parity_d   = (^host.tx_data) ^ parity_odd_i;
          two_stop_d = two_stop_i;
          baud_d     = '0;
          bit_d      = '0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (wrap) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (wrap) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            bit_d = '0;
            if (par_en_q) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (wrap) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (wrap) begin
          baud_d = '0;
          // bit_q doubles as the stop-bit counter once DATA is finished
          if (two_stop_q && (bit_q == '0)) begin
            bit_d = BIT_W'(1);
          end else begin
            bit_d   = '0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      parity_q   <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      parity_q   <= parity_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: each accepted word queues its expected frame,
// and a line monitor checks every cycle of every frame it sees on tx.
module tb_uart_tx_ctrl;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         pen;
    bit         podd;
    bit         two;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baudDiv = '0;
  logic        parityEn = 1'b0;
  logic        parityOdd = 1'b0;
  logic        twoStop = 1'b0;
  logic        txLine;
  logic        busy;
  logic        frameDone;

  int   total = 0;
  int   bad = 0;
  int   cycleCnt = 0;
  int   lastDoneCycle = 0;
  int   numFrames = 0;
  bit   monActive = 1'b0;
  exp_t sbQ[$];
  int   gapQ[$];

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .host         (bus),
    .baud_div_i   (baudDiv),
    .parity_en_i  (parityEn),
    .parity_odd_i (parityOdd),
    .two_stop_i   (twoStop),
    .tx_o         (txLine),
    .busy_o       (busy),
    .frame_done_o (frameDone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Call just after a negedge; returns one negedge after the accept edge.
  task automatic applyStimulus(input logic [7:0] d, input int div, input bit pen,
                               input bit podd, input bit two, input bit holdValid);
    exp_t e;
    int   n;
    bus.tx_data  = d;
    baudDiv      = 16'(div);
    parityEn     = pen;
    parityOdd    = podd;
    twoStop      = two;
    bus.tx_valid = 1'b1;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_wait", 32'(n < 500), 32'd1);
    if (n < 500) begin
      e.data = d; e.div = div; e.pen = pen; e.podd = podd; e.two = two;
      sbQ.push_back(e);
    end
    @(negedge clk);
    if (!holdValid) bus.tx_valid = 1'b0;
  endtask

  task automatic waitIdle(input int maxCyc);
    int n;
    n = 0;
    while ((sbQ.size() != 0 || monActive || busy !== 1'b0) && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", 32'(n < maxCyc), 32'd1);
  endtask

  // Line monitor: frames begin on the first low tx sample outside reset
  initial begin : monitor
    exp_t e;
    logic bits [0:15];
    int   nb;
    int   per;
    bit   aborted;
    forever begin
      @(negedge clk);
      cycleCnt++;
      if (reset === 1'b1 && txLine === 1'b0) begin
        checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          monActive = 1'b1;
          gapQ.push_back(cycleCnt - lastDoneCycle);
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[1 + i] = e.data[i];
          nb = 9;
          if (e.pen) begin bits[nb] = (^e.data) ^ e.podd; nb++; end
          bits[nb] = 1'b1; nb++;
          if (e.two) begin bits[nb] = 1'b1; nb++; end
          per = e.div + 1;
          aborted = 1'b0;
          for (int k = 0; k < nb * per; k++) begin
            if (k > 0) begin @(negedge clk); cycleCnt++; end
            if (reset !== 1'b1) begin aborted = 1'b1; break; end
            checkOutput("tx_bit", 32'(txLine), 32'(bits[k / per]));
            checkOutput("done_mid", 32'(frameDone), 32'd0);
            if (k == 0) begin
              checkOutput("busy_start", 32'(busy), 32'd1);
              checkOutput("ready_start", 32'(bus.tx_ready), 32'd0);
            end
          end
          if (!aborted) begin
            @(negedge clk);
            cycleCnt++;
            if (reset === 1'b1) begin
              checkOutput("done_end", 32'(frameDone), 32'd1);
              checkOutput("ready_end", 32'(bus.tx_ready), 32'd1);
              checkOutput("busy_end", 32'(busy), 32'd0);
              checkOutput("tx_end", 32'(txLine), 32'd1);
              lastDoneCycle = cycleCnt;
              numFrames++;
            end
          end
          monActive = 1'b0;
        end
      end else if (reset === 1'b1) begin
        checkOutput("done_idle", 32'(frameDone), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int startFrames;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    #1 reset = 1'b0;
    #2;
    checkOutput("rst_tx", 32'(txLine), 32'd1);
    checkOutput("rst_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(frameDone), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] basic frames, divisor 3");
    applyStimulus(8'hA5, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    waitIdle(200);
    applyStimulus(8'hA5, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    waitIdle(200);
    applyStimulus(8'hA5, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    waitIdle(200);

    $display("[TB] divisor 0, parity, two stop bits");
    applyStimulus(8'hFF, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    waitIdle(200);

    $display("[TB] back-to-back with ignored mid-frame pulse");
    startFrames = numFrames;
    applyStimulus(8'h01, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h80, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    checkOutput("ready_busy", 32'(bus.tx_ready), 32'd0);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    waitIdle(200);
    checkOutput("b2b_gap", 32'(gapQ[gapQ.size() - 1]), 32'd1);
    checkOutput("b2b_frames", 32'(numFrames - startFrames), 32'd2);

    $display("[TB] settings changed mid-frame");
    applyStimulus(8'hA5, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    baudDiv     = 16'd7;
    parityEn    = 1'b1;
    bus.tx_data = 8'h5A;
    waitIdle(200);
    applyStimulus(8'h5A, 7, 1'b1, 1'b0, 1'b0, 1'b0);
    waitIdle(300);

    $display("[TB] async reset during data bit 4");
    applyStimulus(8'hA5, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (21) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_tx", 32'(txLine), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(bus.tx_ready), 32'd1);
    checkOutput("abort_done", 32'(frameDone), 32'd0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_mon", 32'(monActive), 32'd0);
    applyStimulus(8'h3C, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    waitIdle(200);

    checkOutput("frame_count", 32'(numFrames), 32'd9);
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
